// File: rtl/win_pkg.sv
// Shared types and sizing helpers for the no-border window former.
// Width constants below describe the default 340x240, 7x7, 8-bit configuration.
package win_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACTIVE,
        DONE
    } state_t;

    localparam int unsigned DEF_ROW_WIDTH  = 340;
    localparam int unsigned DEF_NUM_ROWS   = 240;
    localparam int unsigned DEF_PIX_BIT    = 8;
    localparam int unsigned DEF_MASK_WIDTH = 7;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned half_of(input int unsigned mask);
        return (mask - 1) / 2;
    endfunction

    localparam int unsigned COL_W = width_of(DEF_ROW_WIDTH);
    localparam int unsigned ROW_W = width_of(DEF_NUM_ROWS);
    localparam int unsigned WIN_W = DEF_PIX_BIT * DEF_MASK_WIDTH * DEF_MASK_WIDTH;
    localparam int unsigned HALF  = half_of(DEF_MASK_WIDTH);

endpackage

// File: rtl/window_former_no_border_raster_pos_counter.sv
// Raster column/row counters holding the position of the next column to arrive.
// A restart column is itself position (0,0), so the counters move on to (0,1).
module raster_pos_counter
    import win_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int unsigned NUM_ROWS  = DEF_NUM_ROWS,
    parameter int unsigned COL_BITS  = width_of(ROW_WIDTH),
    parameter int unsigned ROW_BITS  = width_of(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                restart,
    output logic [COL_BITS-1:0] col_cnt,
    output logic [ROW_BITS-1:0] row_cnt,
    output logic                end_of_row,
    output logic                end_of_frame
);

    assign end_of_row   = (col_cnt == COL_BITS'(ROW_WIDTH - 1));
    assign end_of_frame = end_of_row && (row_cnt == ROW_BITS'(NUM_ROWS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (en) begin
            if (restart) begin
                col_cnt <= COL_BITS'(1);
                row_cnt <= '0;
            end else if (end_of_row) begin
                col_cnt <= '0;
                row_cnt <= end_of_frame ? '0 : row_cnt + ROW_BITS'(1);
            end else begin
                col_cnt <= col_cnt + COL_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/window_former_no_border.sv
// Shifts row-buffer columns into a MASK_WIDTH x MASK_WIDTH window and flags
// windows lying fully inside the image, with their centre coordinates.
module window_former_no_border
    import win_pkg::*;
#(
    parameter int unsigned ROW_WIDTH  = 340,
    parameter int unsigned NUM_ROWS   = 240,
    parameter int unsigned PIX_BIT    = 8,
    parameter int unsigned MASK_WIDTH = 7
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sof,
    input  logic                                    col_valid,
    input  logic [PIX_BIT*MASK_WIDTH-1:0]           col_pixs_in,
    output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] win_out,
    output logic                                    win_valid,
    output logic [width_of(NUM_ROWS)-1:0]           win_row,
    output logic [width_of(ROW_WIDTH)-1:0]          win_col,
    output logic                                    frame_done
);

    localparam int unsigned COL_BITS   = width_of(ROW_WIDTH);
    localparam int unsigned ROW_BITS   = width_of(NUM_ROWS);
    localparam int unsigned SLICE_BITS = PIX_BIT * MASK_WIDTH;
    localparam int unsigned WIN_BITS   = SLICE_BITS * MASK_WIDTH;
    localparam int unsigned CTR        = half_of(MASK_WIDTH);

    state_t              state, state_nxt;
    logic                done_nxt;
    logic [COL_BITS-1:0] col_cnt, pos_col;
    logic [ROW_BITS-1:0] row_cnt, pos_row;
    logic                end_of_row, end_of_frame;
    logic                restart, accept, pos_in_image;

    assign restart = col_valid & sof;
    assign accept  = restart | (col_valid & ((state == PRIME) | (state == ACTIVE)));

    // Position of the column being accepted this cycle; a sof column is (0,0).
    assign pos_col      = restart ? '0 : col_cnt;
    assign pos_row      = restart ? '0 : row_cnt;
    assign pos_in_image = (pos_row >= ROW_BITS'(MASK_WIDTH - 1)) &&
                          (pos_col >= COL_BITS'(MASK_WIDTH - 1));

    raster_pos_counter #(
        .ROW_WIDTH (ROW_WIDTH),
        .NUM_ROWS  (NUM_ROWS),
        .COL_BITS  (COL_BITS),
        .ROW_BITS  (ROW_BITS)
    ) u_pos (
        .clk          (clk),
        .reset        (reset),
        .en           (accept),
        .restart      (restart),
        .col_cnt      (col_cnt),
        .row_cnt      (row_cnt),
        .end_of_row   (end_of_row),
        .end_of_frame (end_of_frame)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (restart) state_nxt = PRIME;
            end
            PRIME: begin
                if (restart)
                    state_nxt = PRIME;
                else if (col_valid && end_of_row && (row_cnt == ROW_BITS'(MASK_WIDTH - 2)))
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (restart)
                    state_nxt = PRIME;
                else if (col_valid && end_of_frame)
                    state_nxt = DONE;
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = restart ? PRIME : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            win_valid  <= 1'b0;
            win_out    <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
            win_valid  <= accept & pos_in_image;
            if (accept)
                win_out <= {win_out[WIN_BITS-SLICE_BITS-1:0], col_pixs_in};
            if (accept && pos_in_image) begin
                win_row <= pos_row - ROW_BITS'(CTR);
                win_col <= pos_col - COL_BITS'(CTR);
            end
        end
    end

endmodule

// File: doc/window_former_no_border.md
Name: window_former_no_border

Overview:
- Consumer at the far end of the row-buffer column interface.
- Takes one MASK_WIDTH-tall pixel column per valid cycle from the row buffers and shifts it into a MASK_WIDTH x MASK_WIDTH window register.
- Tracks the raster position and asserts a registered window-valid only when the whole window lies inside the image (no-border scheme).
- Feeds the downstream filter arithmetic stage.

Parameters:
- ROW_WIDTH, 340, pixels per image row.
- NUM_ROWS, 240, rows per frame.
- PIX_BIT, 8, bits per pixel.
- MASK_WIDTH, 7, window height and width; odd, 3..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- sof  in  1  start of frame; qualifies the first column of a frame when col_valid=1.
- col_valid  in  1  column input valid.
- col_pixs_in  in  PIX_BIT*MASK_WIDTH  one window column. LSB slice is the current row; the MSB slice is the row MASK_WIDTH-1 rows earlier.
- win_out  out  PIX_BIT*MASK_WIDTH*MASK_WIDTH  window. Column c occupies slice c*PIX_BIT*MASK_WIDTH upward; column 0 is the newest.
- win_valid  out  1  win_out holds a fully in-image window.
- win_row  out  clog2(NUM_ROWS)  centre row of the window.
- win_col  out  clog2(ROW_WIDTH)  centre column of the window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset, asynchronous, active-high:
  - win_out=0, win_valid=0, win_row=0, win_col=0, frame_done=0.
  - Counters cleared; FSM goes to IDLE.
- Reset may assert mid-frame. After release the block waits in IDLE for sof.
- FSM states and transitions:
  - IDLE: waits for col_valid&sof.
  - PRIME: row_cnt<MASK_WIDTH-1.
  - ACTIVE: row_cnt>=MASK_WIDTH-1.
  - DONE: a single cycle that issues frame_done, then returns to IDLE.
  - IDLE->PRIME on col_valid&sof. This column is taken as position (0,0).
  - PRIME->ACTIVE when row_cnt wraps from MASK_WIDTH-2 to MASK_WIDTH-1.
  - ACTIVE->DONE when the column at (NUM_ROWS-1, ROW_WIDTH-1) is accepted.
- Counters:
  - col_cnt increments on each accepted column and wraps at ROW_WIDTH-1 to 0.
  - row_cnt increments on that wrap.
  - Counters change only on col_valid=1. Gaps freeze counters, window and outputs, and win_valid drops to 0 during a gap.
- Window shift: on an accepted column, window columns move one slot toward the MSB. col_pixs_in enters column 0 and column MASK_WIDTH-1 is discarded.
- Validity and timing:
  - win_valid is registered, with latency 1 cycle from the accepted column.
  - win_valid=1 iff row_cnt>=MASK_WIDTH-1 and col_cnt>=MASK_WIDTH-1, evaluated at the accepted column.
  - win_row=row_cnt-(MASK_WIDTH-1)/2 and win_col=col_cnt-(MASK_WIDTH-1)/2, registered together with win_valid.
  - Window contents left over from the previous row are never flagged valid, because col_cnt<MASK_WIDTH-1 at that point.
- Per-frame counts:
  - Windows per frame: (NUM_ROWS-MASK_WIDTH+1)*(ROW_WIDTH-MASK_WIDTH+1).
  - frame_done is asserted the cycle after the final valid window and is never coincident with win_valid=1.
- sof handling:
  - sof with col_valid in PRIME/ACTIVE aborts the current frame: counters restart at (0,0), no frame_done, state goes to PRIME.
  - sof without col_valid is ignored.
- Columns in IDLE without sof are dropped: no shift, no output.
- DONE accepts a simultaneous sof column, starting a new frame at (0,0) in PRIME, and still pulses frame_done.
- Arithmetic: counters are unsigned. The centre subtraction is only performed when valid; win_row/win_col hold their value otherwise.

Decomposition:
- Package win_pkg holds:
  - FSM state encoding (IDLE, PRIME, ACTIVE, DONE).
  - Width constants: COL_W=clog2(ROW_WIDTH), ROW_W=clog2(NUM_ROWS), WIN_W=PIX_BIT*MASK_WIDTH*MASK_WIDTH.
  - HALF=(MASK_WIDTH-1)/2.
- One sub-module, raster_pos_counter: col/row counters with enable, sync restart, end-of-row and end-of-frame flags.
- Window shift register and FSM stay in the top module.

Test Plan:
- Small frame, ROW_WIDTH=16, NUM_ROWS=12, MASK_WIDTH=7, continuous col_valid with sof on first column, pixel value = row*16+col in every slice -> exactly 60 win_valid cycles. First valid has win_row=3, win_col=3; last has win_row=8, win_col=12. frame_done occurs 1 cycle after the last valid.
- Column ordering: same frame with slice k of col_pixs_in = (row-k)*16+col -> at win_row=3, win_col=3, win_out column 0 slice 0 = 6*16+6 and column 6 slice 6 = 0.
- Gaps: deassert col_valid for 5 cycles mid-row 8 -> win_valid=0 during the gap, counters hold, and the total valid count is still 60 with identical coordinates.
- Mid-frame sof at row 5 col 2 -> no frame_done, counters restart; the next 60 valid windows complete normally.
- Async reset asserted mid-ACTIVE, between clock edges -> all outputs 0 immediately. Columns without sof produce nothing; the next sof frame yields 60 windows.
- Back-to-back frames, with sof on the cycle after the last pixel column -> frame_done pulses once and the second frame produces 60 windows with no lost column.
